// File: rtl/uart_tx_arb.sv
// uart_tx_arb: two-requester, packet-granular round-robin arbiter in front of a
// serial byte transmitter. Each accepted byte is registered onto tx_data and
// announced with a one-cycle tx_en strobe. The arbiter then follows the
// transmitter's busy handshake before it offers the next byte.
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to revoke a grant after
// TIMEOUT_CYCLES consecutive SEND cycles in which the owner presents no byte.
module uart_tx_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_en,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       timeout_flag
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SEND      = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_IDLE = 2'd3;

  logic [1:0] state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_grant_q, last_grant_d;  // 0: requester 0 owned last, 1: requester 1
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_en_q, tx_en_d;
  logic       release_q, release_d;        // byte in flight closes the packet
  logic       timeout_flag_q, timeout_flag_d;

  logic       owner_valid;
  logic [7:0] owner_data;
  logic       owner_last;
  logic       accept;
  logic       pick1;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam logic [15:0] TimeoutLim = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt_q, cnt_d;
`endif

  // Mux the current owner's request lines and decide whether a byte is taken.
  always_comb begin
    owner_valid = grant_q[1] ? req1_valid : req0_valid;
    owner_data  = grant_q[1] ? req1_data  : req0_data;
    owner_last  = grant_q[1] ? req1_last  : req0_last;
    accept      = (state_q == ST_SEND) && owner_valid && !tx_busy;
    req0_ready  = accept && grant_q[0];
    req1_ready  = accept && grant_q[1];
  end

  // Next-state logic for the arbiter FSM and its registered outputs.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    tx_data_d      = tx_data_q;
    tx_en_d        = 1'b0;
    release_d      = release_q;
    timeout_flag_d = 1'b0;
    pick1          = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_d          = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          // On a tie, requester 1 wins only if requester 0 owned last.
          pick1     = req1_valid && (!req0_valid || !last_grant_q);
          grant_d   = pick1 ? 2'b10 : 2'b01;
          release_d = 1'b0;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (accept) begin
          tx_data_d = owner_data;
          tx_en_d   = 1'b1;
          release_d = owner_last;
          state_d   = ST_WAIT_BUSY;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (!owner_valid) begin
          if (cnt_q + 16'd1 == TimeoutLim) begin
            grant_d        = 2'b00;
            last_grant_d   = grant_q[1];
            timeout_flag_d = 1'b1;
            state_d        = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
`endif
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) state_d = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (!tx_busy) begin
          if (release_q) begin
            grant_d      = 2'b00;
            last_grant_d = grant_q[1];
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any packet and drops a pending strobe.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      grant_q        <= 2'b00;
      last_grant_q   <= 1'b1;
      tx_data_q      <= 8'h00;
      tx_en_q        <= 1'b0;
      release_q      <= 1'b0;
      timeout_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      tx_data_q      <= tx_data_d;
      tx_en_q        <= tx_en_d;
      release_q      <= release_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  // Idle-cycle counter for the granted requester.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
  assign timeout_flag = timeout_flag_q;
`else
  assign timeout_flag = 1'b0;
`endif

  assign tx_data = tx_data_q;
  assign tx_en   = tx_en_q;
  assign grant   = grant_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a simple busy-counter transmitter model.
module tb_uart_tx_arb;

  logic       CLK;
  logic       reset;
  logic       req0_valid, req0_last, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req1_data;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_busy;
  logic [1:0] grant;
  logic       timeout_flag;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arb #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_last   (req0_last),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_last   (req1_last),
    .req1_ready  (req1_ready),
    .tx_data     (tx_data),
    .tx_en       (tx_en),
    .tx_busy     (tx_busy),
    .grant       (grant),
    .timeout_flag(timeout_flag)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Transmitter model: busy for busy_len cycles starting the cycle after tx_en.
  int         busy_len = 8;
  logic [7:0] busy_cnt;
  always @(posedge CLK or posedge reset) begin
    if (reset)              busy_cnt <= 8'd0;
    else if (tx_en)         busy_cnt <= busy_len[7:0];
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 8'd1;
  end
  assign tx_busy = (busy_cnt != 8'd0);

  // Log of transmitted bytes and monitors.
  logic [7:0] log_data[$];
  logic [1:0] log_grant[$];
  int tx_count = 0;
  bit mon_g01 = 0;
  bit mon_r1  = 0;
  int g_viol  = 0;
  int r1_viol = 0;
  always @(negedge CLK) begin
    if (tx_en) begin
      log_data.push_back(tx_data);
      log_grant.push_back(grant);
      tx_count++;
    end
    if (mon_g01 && grant !== 2'b01) g_viol++;
    if (mon_r1 && req1_ready) r1_viol++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int n);
    return (n == 0) ? req0_ready : req1_ready;
  endfunction

  // Present one byte, wait (bounded) for ready, return on the negedge after acceptance.
  task automatic push_byte(input int n, input logic [7:0] d, input logic l, input string tag);
    bit ok = 0;
    if (n == 0) begin req0_valid = 1; req0_data = d; req0_last = l; end
    else        begin req1_valid = 1; req1_data = d; req1_last = l; end
    for (int i = 0; i < 1000 && !ok; i++) begin
      #1;
      if (rdy(n)) ok = 1;
      @(negedge CLK);
    end
    if (n == 0) req0_valid = 0;
    else        req1_valid = 0;
    check_eq(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    bit ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge CLK);
      if (tx_busy === lvl) ok = 1;
    end
    check_eq(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_grant_idle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge CLK);
      if (grant === 2'b00 && !tx_busy) ok = 1;
    end
    check_eq(tag, 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1;
    repeat (2) @(negedge CLK);
    reset = 0;
    log_data.delete();
    log_grant.delete();
    @(negedge CLK);
  endtask

  int base;
  int cnt;
  bit seen;

  initial begin
    reset = 1;
    req0_valid = 0; req0_data = 8'h00; req0_last = 0;
    req1_valid = 0; req1_data = 8'h00; req1_last = 0;

    // Reset state.
    #3;
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_tx_en", 32'(tx_en), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'h00);
    check_eq("rst_ready0", 32'(req0_ready), 32'd0);
    check_eq("rst_ready1", 32'(req1_ready), 32'd0);
    check_eq("rst_tflag", 32'(timeout_flag), 32'd0);
    repeat (2) @(negedge CLK);
    reset = 0;
    repeat (2) @(negedge CLK);

    // Three-byte packet from req0 with 120-cycle busy; first byte checks latency.
    busy_len = 120;
    req0_valid = 1; req0_data = 8'h48; req0_last = 0;
    #1;
    check_eq("lat_c0_grant", 32'(grant), 32'd0);
    check_eq("lat_c0_ready", 32'(req0_ready), 32'd0);
    @(negedge CLK);
    check_eq("lat_c1_grant", 32'(grant), 32'b01);
    check_eq("lat_c1_ready", 32'(req0_ready), 32'd1);
    mon_g01 = 1;
    @(negedge CLK);
    req0_valid = 0;
    check_eq("lat_c2_tx_en", 32'(tx_en), 32'd1);
    check_eq("lat_c2_data", 32'(tx_data), 32'h48);
    check_eq("lat_c2_ready", 32'(req0_ready), 32'd0);
    @(negedge CLK);
    check_eq("strobe_width", 32'(tx_en), 32'd0);
    check_eq("tx_data_hold", 32'(tx_data), 32'h48);
    push_byte(0, 8'h69, 1'b0, "p1_b1_acc");
    push_byte(0, 8'h0A, 1'b1, "p1_b2_acc");
    wait_busy(1'b1, "p1_busy_rise");
    wait_busy(1'b0, "p1_busy_fall");
    mon_g01 = 0;
    @(negedge CLK);
    check_eq("p1_grant_rel", 32'(grant), 32'd0);
    check_eq("p1_grant_held", 32'(g_viol), 32'd0);
    check_eq("p1_count", 32'(log_data.size()), 32'd3);
    if (log_data.size() == 3) begin
      check_eq("p1_d0", 32'(log_data[0]), 32'h48);
      check_eq("p1_d1", 32'(log_data[1]), 32'h69);
      check_eq("p1_d2", 32'(log_data[2]), 32'h0A);
      check_eq("p1_g2", 32'(log_grant[2]), 32'b01);
    end
    check_eq("p1_tx_data_hold", 32'(tx_data), 32'h0A);

    // Round-robin ties.
    busy_len = 8;
    do_reset();
    fork
      push_byte(0, 8'hA0, 1'b1, "tie1_r0");
      push_byte(1, 8'hB0, 1'b1, "tie1_r1");
    join
    wait_grant_idle("tie1_idle");
    fork
      push_byte(0, 8'hA1, 1'b1, "tie2_r0");
      push_byte(1, 8'hB1, 1'b1, "tie2_r1");
    join
    wait_grant_idle("tie2_idle");
    push_byte(0, 8'hC0, 1'b1, "solo_r0");
    wait_grant_idle("solo_idle");
    fork
      push_byte(0, 8'hD0, 1'b1, "tie3_r0");
      push_byte(1, 8'hD1, 1'b1, "tie3_r1");
    join
    wait_grant_idle("tie3_idle");
    check_eq("tie_count", 32'(log_data.size()), 32'd7);
    if (log_data.size() == 7) begin
      check_eq("tie1_first", 32'(log_data[0]), 32'hA0);
      check_eq("tie1_first_g", 32'(log_grant[0]), 32'b01);
      check_eq("tie1_second", 32'(log_data[1]), 32'hB0);
      check_eq("tie1_second_g", 32'(log_grant[1]), 32'b10);
      check_eq("tie2_first", 32'(log_data[2]), 32'hA1);
      check_eq("tie2_second", 32'(log_data[3]), 32'hB1);
      check_eq("tie3_first", 32'(log_data[5]), 32'hD1);
      check_eq("tie3_first_g", 32'(log_grant[5]), 32'b10);
      check_eq("tie3_second", 32'(log_data[6]), 32'hD0);
    end

    // Req1 arrives mid-packet and must wait for req0's packet to finish.
    do_reset();
    fork
      begin
        push_byte(0, 8'h31, 1'b0, "mid_b0");
        push_byte(0, 8'h32, 1'b0, "mid_b1");
        push_byte(0, 8'h33, 1'b1, "mid_b2");
        for (int i = 0; i < 1000 && grant !== 2'b00; i++) @(negedge CLK);
        mon_r1 = 0;
      end
      begin
        repeat (16) @(negedge CLK);
        mon_r1 = 1;
        push_byte(1, 8'hEE, 1'b1, "mid_r1");
      end
    join
    wait_grant_idle("mid_idle");
    check_eq("mid_r1_blocked", 32'(r1_viol), 32'd0);
    check_eq("mid_count", 32'(log_data.size()), 32'd4);
    if (log_data.size() == 4) begin
      check_eq("mid_d2", 32'(log_data[2]), 32'h33);
      check_eq("mid_d3", 32'(log_data[3]), 32'hEE);
      check_eq("mid_g3", 32'(log_grant[3]), 32'b10);
    end

    // Reset during WAIT_BUSY of byte 2.
    do_reset();
    push_byte(0, 8'h11, 1'b0, "rmid_b0");
    wait_busy(1'b0, "rmid_busy_fall");
    push_byte(0, 8'h22, 1'b0, "rmid_b1");
    check_eq("rmid_strobe", 32'(tx_en), 32'd1);
    reset = 1;
    #1;
    check_eq("rmid_tx_en", 32'(tx_en), 32'd0);
    check_eq("rmid_grant", 32'(grant), 32'd0);
    check_eq("rmid_tx_data", 32'(tx_data), 32'h00);
    check_eq("rmid_ready0", 32'(req0_ready), 32'd0);
    @(negedge CLK);
    reset = 0;
    base = tx_count;
    repeat (30) @(negedge CLK);
    check_eq("rmid_no_tx", 32'(tx_count - base), 32'd0);
    check_eq("rmid_grant_idle", 32'(grant), 32'd0);
    push_byte(0, 8'h33, 1'b1, "rmid_new");
    check_eq("rmid_new_data", 32'(tx_data), 32'h33);
    wait_grant_idle("rmid_idle");

    // Owner stops sending mid-packet.
    do_reset();
`ifdef UART_TX_ARB_TIMEOUT_EN
    push_byte(0, 8'h55, 1'b0, "to_b0");
    req1_valid = 1; req1_data = 8'h66; req1_last = 1;
    wait_busy(1'b1, "to_busy_rise");
    wait_busy(1'b0, "to_busy_fall");
    cnt = 0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK);
      cnt++;
      if (timeout_flag) seen = 1;
    end
    check_eq("to_flag_seen", 32'(seen), 32'd1);
    check_eq("to_flag_delay", 32'(cnt), 32'd17);
    check_eq("to_grant_rel", 32'(grant), 32'd0);
    @(negedge CLK);
    check_eq("to_flag_pulse", 32'(timeout_flag), 32'd0);
    check_eq("to_grant_r1", 32'(grant), 32'b10);
    check_eq("to_ready_r1", 32'(req1_ready), 32'd1);
    @(negedge CLK);
    req1_valid = 0;
    check_eq("to_tx_r1", 32'(tx_data), 32'h66);
`else
    push_byte(0, 8'h55, 1'b0, "hold_b0");
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (timeout_flag) cnt++;
    end
    check_eq("hold_grant", 32'(grant), 32'b01);
    check_eq("hold_no_flag", 32'(cnt), 32'd0);
    check_eq("hold_ready0", 32'(req0_ready), 32'd0);
`endif
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
